// File: rtl/buffer_pool_reader_pkg.sv
// Shared widths, BRAM read latency and controller state encoding for the
// BufferPool read path.
package buffer_pool_reader_pkg;

    localparam int X_MAC        = 4;
    localparam int X_MESH       = 16;
    localparam int ADDR_LEN     = 13;
    localparam int DATA_LEN     = 32;
    // Must match the BufferPool BRAM configuration (output register enabled).
    localparam int READ_LATENCY = 2;
    // Must be at least 2*(READ_LATENCY+1) to sustain one beat per cycle.
    localparam int FIFO_DEPTH   = 8;

    localparam int BUFFER_NUM   = X_MAC * X_MESH;
    localparam int DATAWIDTH    = BUFFER_NUM * DATA_LEN;
    localparam int ADDRWIDTH    = BUFFER_NUM * ADDR_LEN;

    localparam int LEN_W        = ADDR_LEN + 1;
    localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // Number of set bits in the token valid pipeline.
    function automatic logic [CNT_W-1:0] count_tokens(input logic [READ_LATENCY:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i <= READ_LATENCY; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/buffer_pool_rd_fifo.sv
// Output FIFO for pool read data. The head entry lives in a register so the
// stream outputs never come straight from combinational logic; when the
// storage array is empty a write goes directly into that register, giving a
// one-cycle write-to-valid latency.
module buffer_pool_rd_fifo #(
    parameter int WIDTH = 2049,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic                         rd_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] mem_cnt_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;

    logic pop;
    logic out_free;
    logic mem_empty;
    logic load_from_mem;
    logic bypass;
    logic mem_wr;

    assign pop           = out_valid_q && rd_en_i;
    assign out_free      = !out_valid_q || pop;
    assign mem_empty     = (mem_cnt_q == '0);
    assign load_from_mem = out_free && !mem_empty;
    assign bypass        = out_free && mem_empty && wr_en_i;
    assign mem_wr        = wr_en_i && !bypass;

    assign rd_data_o  = out_data_q;
    assign rd_valid_o = out_valid_q;
    assign count_o    = mem_cnt_q + CNT_W'(out_valid_q);

    // Storage array write port; left unreset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers, occupancy and the registered head entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (mem_wr) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (load_from_mem) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (mem_wr && !load_from_mem) begin
                mem_cnt_q <= mem_cnt_q + CNT_W'(1);
            end else if (!mem_wr && load_from_mem) begin
                mem_cnt_q <= mem_cnt_q - CNT_W'(1);
            end
            if (load_from_mem) begin
                out_data_q  <= mem_q[rd_ptr_q];
                out_valid_q <= 1'b1;
            end else if (bypass) begin
                out_data_q  <= wr_data_i;
                out_valid_q <= 1'b1;
            end else if (out_free) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // The upstream credit scheme must never write into a full FIFO.
    assert property (@(posedge clk) disable iff (rst) !(wr_en_i && (count_o == CNT_W'(DEPTH))))
        else $error("buffer_pool_rd_fifo overflow");

endmodule

// File: rtl/buffer_pool_reader.sv
// Read-side controller for the BufferPool BRAM array: issues a burst of
// addresses (broadcast to every lane), follows the fixed BRAM latency with a
// token pipeline, captures the returned rows into a credit-managed FIFO and
// streams them out with a last flag.
module buffer_pool_reader
    import buffer_pool_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_LEN-1:0]   cmd_base,
    input  logic [ADDR_LEN:0]     cmd_len,
    output logic [ADDRWIDTH-1:0]  addrb,
    input  logic [DATAWIDTH-1:0]  doutb,
    output logic [DATAWIDTH-1:0]  m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

    rd_state_e              state_q;
    logic [ADDR_LEN-1:0]    addr_q;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       issue_cnt_q;
    logic                   done_zero_q;
    logic                   busy_q;
    logic                   cmd_ready_q;
    // Stage 0 belongs to the address currently on addrb; stage READ_LATENCY
    // is the one whose data is on doutb this cycle.
    logic [READ_LATENCY:0]  tok_valid_q;
    logic [READ_LATENCY:0]  tok_last_q;

    logic                   accept;
    logic                   accept_zero;
    logic                   accept_burst;
    logic [CNT_W-1:0]       fifo_count;
    logic [CNT_W-1:0]       inflight;
    logic [CNT_W:0]         credit_used;
    logic                   credit_ok;
    logic                   issue_more;
    logic                   issue_now;
    logic                   issue_last;
    logic                   last_handshake;
    logic [DATAWIDTH:0]     fifo_rd_data;
    logic                   fifo_rd_valid;

    assign accept       = cmd_valid && cmd_ready_q;
    assign accept_zero  = accept && (cmd_len == '0);
    assign accept_burst = accept && (cmd_len != '0);

    // Reads already launched but not yet in the FIFO count against its space;
    // a pop happening this same cycle is deliberately not credited.
    assign inflight    = count_tokens(tok_valid_q);
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign credit_ok   = credit_used < CREDIT_LIMIT;

    // The first address of a burst issues on the accept edge itself so that it
    // is on addrb the cycle after the command handshake.
    assign issue_more = (state_q == ISSUE) && (issue_cnt_q < len_q) && credit_ok;
    assign issue_now  = accept_burst || issue_more;
    assign issue_last = accept_burst ? (cmd_len == LEN_W'(1))
                                     : ((issue_cnt_q + LEN_W'(1)) == len_q);

    assign last_handshake = (state_q == DRAIN) && m_valid && m_ready && m_last;

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_zero_q || last_handshake;
    assign m_valid   = fifo_rd_valid;
    assign m_data    = fifo_rd_data[DATAWIDTH-1:0];
    assign m_last    = fifo_rd_valid && fifo_rd_data[DATAWIDTH];

    // Burst controller: command accept, address issue and drain tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            done_zero_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            done_zero_q <= accept_zero;
            case (state_q)
                IDLE: begin
                    if (accept_burst) begin
                        len_q       <= cmd_len;
                        addr_q      <= cmd_base;
                        issue_cnt_q <= LEN_W'(1);
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= issue_last ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_more) begin
                        // Wrap past the top of the buffer is intentional.
                        addr_q      <= addr_q + ADDR_LEN'(1);
                        issue_cnt_q <= issue_cnt_q + LEN_W'(1);
                        if (issue_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_handshake) begin
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Token pipeline that mirrors the BRAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_valid_q <= '0;
            tok_last_q  <= '0;
        end else begin
            tok_valid_q <= {tok_valid_q[READ_LATENCY-1:0], issue_now};
            tok_last_q  <= {tok_last_q[READ_LATENCY-1:0], issue_now && issue_last};
        end
    end

    // Every pool lane reads the same row.
    for (genvar gi = 0; gi < BUFFER_NUM; gi++) begin : g_lane
        assign addrb[gi*ADDR_LEN +: ADDR_LEN] = addr_q;
    end

    buffer_pool_rd_fifo #(
        .WIDTH (DATAWIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (tok_valid_q[READ_LATENCY]),
        .wr_data_i  ({tok_last_q[READ_LATENCY], doutb}),
        .rd_en_i    (m_ready),
        .rd_data_o  (fifo_rd_data),
        .rd_valid_o (fifo_rd_valid),
        .count_o    (fifo_count)
    );

endmodule

// File: tb/tb_buffer_pool_reader.sv
// Directed bench for buffer_pool_reader with a behavioural two-cycle BRAM
// model whose contents are a known function of address and lane.
module tb_buffer_pool_reader;
    import buffer_pool_reader_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_LEN-1:0]   cmd_base;
    logic [ADDR_LEN:0]     cmd_len;
    logic [ADDRWIDTH-1:0]  addrb;
    logic [DATAWIDTH-1:0]  doutb;
    logic [DATAWIDTH-1:0]  m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic                  busy;
    logic                  done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    buffer_pool_reader dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .addrb     (addrb),
        .doutb     (doutb),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [DATA_LEN-1:0] pool_word(input logic [ADDR_LEN-1:0] a, input int lane);
        logic [7:0] l8;
        l8 = lane[7:0];
        return {l8, 3'b101, a, 8'h5A};
    endfunction

    function automatic logic [DATAWIDTH-1:0] pool_row(input logic [ADDR_LEN-1:0] a);
        logic [DATAWIDTH-1:0] r;
        for (int j = 0; j < BUFFER_NUM; j++) r[j*DATA_LEN +: DATA_LEN] = pool_word(a, j);
        return r;
    endfunction

    function automatic logic [ADDRWIDTH-1:0] addr_row(input logic [ADDR_LEN-1:0] a);
        logic [ADDRWIDTH-1:0] r;
        for (int j = 0; j < BUFFER_NUM; j++) r[j*ADDR_LEN +: ADDR_LEN] = a;
        return r;
    endfunction

    // Pool model: address registered, then data registered (latency 2).
    logic [ADDR_LEN-1:0] pool_addr_q = '0;
    always @(posedge clk) begin
        pool_addr_q <= addrb[ADDR_LEN-1:0];
        doutb       <= pool_row(pool_addr_q);
    end

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_addr(input string name, input logic [ADDRWIDTH-1:0] act, input logic [ADDR_LEN-1:0] exp);
        n_cmp++;
        if (act !== addr_row(exp)) begin
            n_bad++;
            $display("FAIL %s: addrb lane0 got %h want %h on all lanes (cycle %0d)",
                     name, act[ADDR_LEN-1:0], exp, cyc);
        end
    endtask

    task automatic chk_data(input string name, input logic [DATAWIDTH-1:0] act, input logic [ADDR_LEN-1:0] exp_addr);
        logic [DATAWIDTH-1:0] e;
        e = pool_row(exp_addr);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: lane0 got %h want %h, lane63 got %h want %h (cycle %0d)",
                     name, act[DATA_LEN-1:0], e[DATA_LEN-1:0],
                     act[DATAWIDTH-1 -: DATA_LEN], e[DATAWIDTH-1 -: DATA_LEN], cyc);
        end
    endtask

    // Runs one burst from the command offer to the last beat. Called at a
    // falling edge. With preoffered the command lines are already driven and
    // must be taken at the next rising edge; with hold_next the next command is
    // kept on the bus during this burst to check it is not taken early.
    task automatic run_burst(input logic [ADDR_LEN-1:0] base, input logic [ADDR_LEN:0] len,
                             input int duty, input logic [ADDR_LEN-1:0] exp_last,
                             input bit preoffered, input bit hold_next,
                             input logic [ADDR_LEN-1:0] next_base, input logic [ADDR_LEN:0] next_len);
        int k;
        int beat;
        bit fin;
        bit seen_valid;
        logic rdy;
        logic [ADDR_LEN-1:0] ea;
        if (!preoffered) begin
            k = 0;
            while (!cmd_ready && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk_bit("cmd_ready_before_offer", cmd_ready, 1'b1);
            cmd_base  = base;
            cmd_len   = len;
            cmd_valid = 1'b1;
        end else begin
            chk_bit("cmd_ready_after_prev_burst", cmd_ready, 1'b1);
        end
        @(negedge clk);
        if (hold_next) begin
            cmd_base  = next_base;
            cmd_len   = next_len;
            cmd_valid = 1'b1;
        end else begin
            cmd_valid = 1'b0;
        end
        k = 1;
        beat = 0;
        fin = 1'b0;
        seen_valid = 1'b0;
        while (!fin && k < 3000) begin
            rdy = (int'($urandom_range(0, 99)) < duty);
            m_ready = rdy;
            #1;
            chk_bit("busy_during_burst", busy, 1'b1);
            chk_bit("cmd_ready_during_burst", cmd_ready, 1'b0);
            chk_bit("fifo_count_bound", (dut.fifo_count <= CNT_W'(FIFO_DEPTH)), 1'b1);
            if (m_valid && !seen_valid) begin
                seen_valid = 1'b1;
                chk_int("first_valid_latency", k, 2 + READ_LATENCY);
            end
            if (m_valid) begin
                ea = base + ADDR_LEN'(beat);
                chk_data("beat_data", m_data, ea);
                chk_bit("beat_last", m_last, (beat == int'(len) - 1));
            end
            chk_bit("done_pulse", done, m_valid && rdy && (beat == int'(len) - 1));
            if (m_valid && rdy) begin
                beat++;
                if (beat == int'(len)) fin = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL burst_timeout: got %0d beats want %0d (cycle %0d)", beat, len, cyc);
        end
        chk_int("beat_count", beat, int'(len));
        chk_bit("busy_after_burst", busy, 1'b0);
        chk_bit("cmd_ready_after_burst", cmd_ready, 1'b1);
        chk_bit("done_after_burst", done, 1'b0);
        chk_addr("addrb_hold_after_burst", addrb, exp_last);
        if (!hold_next) begin
            for (int i = 0; i < 3; i++) begin
                chk_bit("no_extra_beat", m_valid, 1'b0);
                @(negedge clk);
            end
        end
        $display("burst base=%h len=%0d duty=%0d beats=%0d cycles=%0d", base, len, duty, beat, k);
    endtask

    typedef struct {
        logic [ADDR_LEN-1:0] base;
        logic [ADDR_LEN:0]   len;
        int                  duty;
        logic [ADDR_LEN-1:0] exp_last;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [ADDR_LEN-1:0] ea;
        int nb;
        int k;

        vecs[0] = '{13'h1FFE, 14'd4,  100, 13'h0001};   // wrap at top of buffer
        vecs[1] = '{13'h0100, 14'd32, 30,  13'h011F};   // heavy backpressure
        vecs[2] = '{13'h1FFF, 14'd1,  100, 13'h1FFF};   // single beat at top
        vecs[3] = '{13'h0ABC, 14'd9,  60,  13'h0AC4};   // moderate backpressure
        vecs[4] = '{13'h1FF0, 14'd20, 100, 13'h0003};   // long burst through wrap

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        m_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk_addr("reset_addrb", addrb, 13'h0000);
        chk_bit("reset_m_valid", m_valid, 1'b0);
        chk_bit("reset_m_last", m_last, 1'b0);
        chk_bit("reset_m_data_zero", (m_data == '0), 1'b1);
        chk_bit("reset_busy", busy, 1'b0);
        chk_bit("reset_done", done, 1'b0);
        chk_bit("reset_cmd_ready", cmd_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk_bit("post_reset_cmd_ready", cmd_ready, 1'b1);
        chk_bit("post_reset_m_valid", m_valid, 1'b0);
        $display("reset sequence checked");

        // Basic burst with exact cycle timing, accept cycle c = this cycle.
        m_ready   = 1'b1;
        cmd_base  = 13'h0010;
        cmd_len   = 14'd4;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int kk = 1; kk <= 9; kk++) begin
            ea = (kk <= 4) ? 13'h0010 + ADDR_LEN'(kk - 1) : 13'h0013;
            chk_addr($sformatf("basic_addrb_c%0d", kk), addrb, ea);
            chk_bit($sformatf("basic_m_valid_c%0d", kk), m_valid, (kk >= 4 && kk <= 7));
            if (kk >= 4 && kk <= 7) begin
                chk_data($sformatf("basic_data_c%0d", kk), m_data, 13'h0010 + ADDR_LEN'(kk - 4));
            end
            chk_bit($sformatf("basic_m_last_c%0d", kk), m_last, (kk == 7));
            chk_bit($sformatf("basic_done_c%0d", kk), done, (kk == 7));
            chk_bit($sformatf("basic_busy_c%0d", kk), busy, (kk <= 7));
            @(negedge clk);
        end
        $display("burst base=010 len=4 exact timing checked");

        for (int v = 0; v < 5; v++) begin
            run_burst(vecs[v].base, vecs[v].len, vecs[v].duty, vecs[v].exp_last,
                      1'b0, 1'b0, '0, '0);
        end

        // Zero-length command: only a done pulse one cycle after accept.
        m_ready   = 1'b1;
        cmd_base  = 13'h00AA;
        cmd_len   = 14'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk_bit("zero_done", done, 1'b1);
        chk_bit("zero_busy", busy, 1'b0);
        chk_bit("zero_m_valid", m_valid, 1'b0);
        chk_bit("zero_cmd_ready", cmd_ready, 1'b1);
        chk_addr("zero_addrb_unchanged", addrb, 13'h0003);
        @(negedge clk);
        chk_bit("zero_done_cleared", done, 1'b0);
        chk_bit("zero_busy_later", busy, 1'b0);
        chk_bit("zero_m_valid_later", m_valid, 1'b0);
        chk_addr("zero_addrb_later", addrb, 13'h0003);
        $display("zero-length command checked");

        // Reset in the middle of a 16-beat burst.
        m_ready   = 1'b1;
        cmd_base  = 13'h0200;
        cmd_len   = 14'd16;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        nb = 0;
        k = 0;
        while (nb < 5 && k < 100) begin
            if (m_valid) nb++;
            @(negedge clk);
            k++;
        end
        chk_int("midburst_beats_before_reset", nb, 5);
        rst = 1'b1;
        #1;
        chk_addr("midreset_addrb", addrb, 13'h0000);
        chk_bit("midreset_m_valid", m_valid, 1'b0);
        chk_bit("midreset_m_last", m_last, 1'b0);
        chk_bit("midreset_m_data_zero", (m_data == '0), 1'b1);
        chk_bit("midreset_busy", busy, 1'b0);
        chk_bit("midreset_done", done, 1'b0);
        chk_bit("midreset_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_bit("after_midreset_m_valid", m_valid, 1'b0);
        $display("reset mid-burst checked");
        run_burst(13'h0300, 14'd2, 100, 13'h0301, 1'b0, 1'b0, '0, '0);

        // Back-to-back: second command held on the bus during the first burst.
        run_burst(13'h0050, 14'd6, 100, 13'h0055, 1'b0, 1'b1, 13'h0060, 14'd3);
        run_burst(13'h0060, 14'd3, 50,  13'h0062, 1'b1, 1'b0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/buffer_pool_reader.md
Name: buffer_pool_reader

Overview:
- Read-side controller for the BufferPool BRAM array.
- Accepts a burst command (base address, length) and drives the pool's read-port address bus `addrb` with one address, broadcast to all BUFFER_NUM lanes.
- Tracks the fixed BRAM read latency and captures the pool's `doutb` into a small credit-managed FIFO.
- Presents the full-width data as a valid/ready stream with a `last` flag to the downstream compute mesh.

Parameters:
- X_MAC, 4, MAC lanes per mesh port
- X_MESH, 16, mesh ports
- ADDR_LEN, 13, per-buffer address width
- DATA_LEN, 32, per-buffer word width
- READ_LATENCY, 2, cycles from `addrb` to valid `doutb` (HIGH_PERFORMANCE BRAM)
- FIFO_DEPTH, 8, output FIFO entries; must be >= 2*(READ_LATENCY+1)
- BUFFER_NUM, X_MAC*X_MESH, derived
- DATAWIDTH, BUFFER_NUM*DATA_LEN, derived
- ADDRWIDTH, BUFFER_NUM*ADDR_LEN, derived

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE
- cmd_base  input  ADDR_LEN  first read address
- cmd_len  input  ADDR_LEN+1  word count, 0..2**ADDR_LEN
- addrb  output  ADDRWIDTH  registered read address to the pool; same value on every lane
- doutb  input  DATAWIDTH  read data from the pool
- m_data  output  DATAWIDTH  stream data
- m_valid  output  1  stream valid
- m_ready  input  1  stream ready
- m_last  output  1  marks the final beat of a burst
- busy  output  1  high from command accept until the last beat is handed off
- done  output  1  one-cycle pulse on the last-beat handshake, or on a zero-length command

Behaviour:
- Reset values: `addrb`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0, `done`=0, `cmd_ready`=1. FIFO, valid pipeline and counters are all cleared.
- Reset mid-burst abandons the burst with no `done` pulse. The first cycle after deassertion is IDLE.
- IDLE:
  - On `cmd_valid` && `cmd_ready`, latch base and len.
  - If len==0: pulse `done` next cycle and stay in IDLE.
  - Otherwise: `busy`=1, go to ISSUE.
- ISSUE, each cycle:
  - If issue_count < len and (fifo_count + inflight) < FIFO_DEPTH, register `addrb` = (base + issue_count) mod 2**ADDR_LEN and increment issue_count.
  - Push a token {valid=1, last=(issue_count==len-1)} into a READ_LATENCY-deep shift register; otherwise push an invalid token.
  - Address wrap past 2**ADDR_LEN-1 to 0 is silent.
  - When the final address issues, go to DRAIN.
- DRAIN: no new addresses; `addrb` holds its last value. Return to IDLE on the `m_last` handshake; `done` pulses that same cycle.
- Capture: when a token exits the shift register, i.e. READ_LATENCY cycles after its address appears on `addrb`, write `doutb` and the token's last bit into the FIFO in that cycle.
- inflight = number of valid tokens in the shift register, including the one issued this cycle.
- Credit check uses the current-cycle counts; a same-cycle pop is not credited. The FIFO can never overflow; an overflow is an assertion failure.
- FIFO output is registered (no fall-through). Capture in cycle t gives `m_valid` at t+1.
- Latency: command accepted at cycle c, first address at c+1, first `m_valid` at c+2+READ_LATENCY (c+4 by default).
- Throughput: with `m_ready` held high, one beat per cycle.
- Handshake:
  - `m_data`/`m_last` are stable while `m_valid` && !`m_ready`.
  - A beat transfers on `m_valid` && `m_ready`.
  - No beat is lost or duplicated; order equals address order.
- `cmd_valid` while busy is ignored (`cmd_ready`=0). Simultaneous last handshake and new `cmd_valid`: the command is accepted the following cycle.
- BRAM `enb` is tied high by the integrator, so the read pipeline never stalls. Backpressure acts only via credits.

Decomposition:
- Shared package holds:
  - derived widths BUFFER_NUM, DATAWIDTH, ADDRWIDTH
  - READ_LATENCY constant shared with BufferPool
  - state encoding IDLE/ISSUE/DRAIN
- Sub-module buffer_pool_rd_fifo: synchronous FIFO, width DATAWIDTH+1, depth FIFO_DEPTH. It has count output, registered read port and async active-high reset.
- Address replication is a generate loop inside the top module.

Test Plan:
- Basic burst: base=0x010, len=4, `m_ready`=1 -> `addrb` lanes all 0x010..0x013 on cycles c+1..c+4. Beats on c+4..c+7 carry pool contents 0x010..0x013, `m_last` on the 4th beat, `done` at c+7.
- Wrap: base=0x1FFE, len=4 -> addresses 0x1FFE, 0x1FFF, 0x000, 0x001; data in that order.
- Backpressure: len=32, `m_ready` random 30% duty -> exactly 32 beats in order, FIFO count never exceeds 8, no overflow assertion, `m_data` stable while stalled.
- Zero length: cmd_len=0 -> no `addrb` change, no `m_valid`, `done` pulse one cycle after accept, `busy` stays 0.
- Reset mid-burst: assert `rst` after 5 beats of a len=16 burst -> all outputs at reset values immediately. A new len=2 burst then yields exactly 2 beats with no stale data.
- Back-to-back: second command offered during the first burst -> `cmd_ready`=0 until the first burst's `m_last` handshake. The second burst then completes correctly.
